// File: rtl/button_event_unit.sv
// Per-channel button front end: 2-flop synchronizer, debouncer, and a press/long-press FSM.
// Every event output is registered and gated by that channel's enable, sampled on the event edge.
module button_event_unit #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic             clk_100_i,
  input  logic             s_rst_i,
  input  logic [N_BTN-1:0] buttons_i,
  input  logic [N_BTN-1:0] enable_i,
  output logic [N_BTN-1:0] held_o,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic [N_BTN-1:0] click_o,
  output logic [N_BTN-1:0] long_press_o
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_e;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic          s1_q, s2_q;
    logic          deb_q, deb_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [LW-1:0] hold_q;
    state_e        state_q;
    logic          held_q, press_q, release_q, click_q, long_q;
    logic          rise, fall;

    always_comb begin
      deb_d  = deb_q;
      dcnt_d = '0;
      if (s2_q != deb_q) begin
        if (dcnt_q == DEB_LAST) begin
          deb_d = ~deb_q;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end else begin
        dcnt_d = '0;
      end
    end

    // The debounced level is re-registered into held_q, so edges are seen one cycle later
    // as a mismatch between the two; this gives registered held/press/release on one edge.
    assign rise = deb_q & ~held_q;
    assign fall = ~deb_q & held_q;

    always_ff @(posedge clk_100_i) begin
      if (s_rst_i) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        deb_q     <= 1'b0;
        dcnt_q    <= '0;
        hold_q    <= '0;
        state_q   <= RELEASED;
        held_q    <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        click_q   <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        s1_q      <= buttons_i[i];
        s2_q      <= s1_q;
        deb_q     <= deb_d;
        dcnt_q    <= dcnt_d;
        held_q    <= deb_q;
        press_q   <= rise & enable_i[i];
        release_q <= fall & enable_i[i];
        click_q   <= 1'b0;
        long_q    <= 1'b0;
        case (state_q)
          RELEASED: begin
            if (rise) begin
              state_q <= PRESSED;
              hold_q  <= '0;
            end
          end
          PRESSED: begin
            // A release on the same edge as the long threshold counts as a click.
            if (fall) begin
              state_q <= RELEASED;
              click_q <= enable_i[i];
            end else if (hold_q == LONG_LAST) begin
              state_q <= LONG_HELD;
              long_q  <= enable_i[i];
            end else begin
              hold_q <= hold_q + LW'(1);
            end
          end
          LONG_HELD: begin
            if (fall) begin
              state_q <= RELEASED;
            end
          end
          default: state_q <= RELEASED;
        endcase
      end
    end

    assign held_o[i]       = held_q;
    assign press_o[i]      = press_q;
    assign release_o[i]    = release_q;
    assign click_o[i]      = click_q;
    assign long_press_o[i] = long_q;
  end
endmodule

// File: doc/button_event_unit.md
BUTTON_EVENT_UNIT -- requirements
Module: button_event_unit

Interface
REQ-001 Parameter N_BTN, default 2: number of independent button channels, legal range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz), minimum 1.
REQ-003 Parameter LONG_CYCLES, default 100000000: cycles a debounced press must persist to raise a long-press event (1 s at 100 MHz), minimum 1.
REQ-004 clk_100  input  1  sole clock; all logic on its rising edge.
REQ-005 s_rst  input  1  reset, synchronous, active-high.
REQ-006 buttons  input  N_BTN  raw asynchronous button levels, 1 = pressed.
REQ-007 enable  input  N_BTN  per-channel event enable.
REQ-008 held  output  N_BTN  debounced button level per channel.
REQ-009 press  output  N_BTN  one-cycle pulse on debounced 0->1.
REQ-010 release  output  N_BTN  one-cycle pulse on debounced 1->0.
REQ-011 click  output  N_BTN  one-cycle pulse on a release that ends a press shorter than LONG_CYCLES.
REQ-012 long_press  output  N_BTN  one-cycle pulse when a press reaches LONG_CYCLES.

Function
REQ-013 Each channel SHALL pass buttons[i] through a 2-flop synchronizer; sync[i] is buttons[i] delayed by 2 cycles.
REQ-014 Per channel, a debounce counter of width $clog2(DEBOUNCE_CYCLES+1) SHALL increment each cycle sync != held and clear to 0 in any cycle sync == held.
REQ-015 When sync != held and the counter equals DEBOUNCE_CYCLES-1, held SHALL toggle on the next edge and the counter SHALL clear.
REQ-016 Latency: a clean raw step sampled at edge k SHALL change held at edge k+2+DEBOUNCE_CYCLES; press/release SHALL assert on that same edge.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave held unchanged and produce no pulse.
REQ-018 Per-channel FSM states: RELEASED, PRESSED, LONG_HELD; reset state RELEASED.
REQ-019 RELEASED -> PRESSED on debounced 0->1; hold counter cleared.
REQ-020 PRESSED: hold counter ($clog2(LONG_CYCLES+1) bits) increments each cycle; at LONG_CYCLES-1 -> LONG_HELD with long_press pulse on that edge.
REQ-021 PRESSED -> RELEASED on debounced 1->0 with release and click pulses on the same edge.
REQ-022 LONG_HELD -> RELEASED on debounced 1->0 with release pulse only; hold counter stays frozen in LONG_HELD (no wrap, no repeat long_press).
REQ-023 If the debounced release and the hold counter reaching LONG_CYCLES-1 occur on the same edge, release SHALL win: RELEASED, release and click asserted, no long_press.
REQ-024 press, release, click, long_press SHALL be ANDed with enable[i] registered at the event edge; the FSM and held SHALL update regardless of enable.
REQ-025 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 While s_rst is high at a clock edge: synchronizers, debounce and hold counters clear to 0, all FSMs enter RELEASED, all outputs 0.
REQ-028 A button held during reset SHALL, after reset deasserts, be debounced from 0 and produce press at the normal latency.
REQ-029 Reset asserted mid-press or mid-debounce SHALL abandon the operation with no release, click or long_press pulse.

Verification (N_BTN=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10)
REQ-030 buttons[0] 0->1 sampled at edge 0, held -> held[0]=1 and press[0]=1 exactly at edge 6, single-cycle pulse.
REQ-031 buttons[0] high 3 cycles then low -> held, press, release stay 0 throughout.
REQ-032 Press held 20 cycles after debounce -> long_press[0] once, 10 cycles after press; later release gives release[0]=1, click[0]=0.
REQ-033 Press debounced then released 5 cycles later -> release[0]=1 and click[0]=1 on the same edge, no long_press.
REQ-034 enable=2'b01, both buttons pressed together -> held=2'b11, press=2'b01 on the same edge.
REQ-035 s_rst pulsed while buttons[1] held in PRESSED -> all outputs 0 next edge; no release; press[1] reappears 6 cycles after reset deasserts.
